// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I pipeline.
//   XLEN       datapath width
//   alu_op_t   4-bit ALU operation codes
//   fwd_sel_t  operand forwarding source select
//   idex_t     ID/EX pipeline register contents
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLL  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_t;

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic            alu_src;
    logic [1:0]      result_src;
    logic [3:0]      alu_ctrl;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } idex_t;

endpackage

// File: rtl/alu.sv
// Combinational RV32I ALU.
//   src_a, src_b  operands
//   op            operation code (unlisted codes yield 0)
//   result        operation result
//   zero          result == 0
module alu
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  alu_op_t         op,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  logic signed [XLEN-1:0] src_a_s;
  logic signed [XLEN-1:0] src_b_s;
  logic        [4:0]      shamt;

  assign src_a_s = src_a;
  assign src_b_s = src_b;
  assign shamt   = src_b[4:0];

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = src_a + src_b;
      ALU_SUB:  result = src_a - src_b;
      ALU_AND:  result = src_a & src_b;
      ALU_OR:   result = src_a | src_b;
      ALU_XOR:  result = src_a ^ src_b;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, (src_a_s < src_b_s)};
      ALU_SRL:  result = src_a >> shamt;
      ALU_SRA:  result = src_a_s >>> shamt;
      ALU_SLL:  result = src_a << shamt;
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID/EX register, operand forwarding, ALU and branch/jump
// resolution.
//   clk, reset            clock, async active-high reset
//   StallE, FlushE        hazard-unit hold / bubble insert (flush wins)
//   *D                    decode-stage controls, operands and indices
//   ALUResultM/RdM/RegWriteM  MEM-stage forward source
//   ResultW/RdW/RegWriteW     WB-stage forward source
//   ALUResultE, WriteDataE    ALU result and forwarded store data
//   PCSrcE, PCTargetE         redirect request to fetch
//   remaining *E              registered D fields
module ex_stage
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            StallE,
  input  logic            FlushE,
  input  logic            ValidD,
  input  logic            RegWriteD,
  input  logic            MemWriteD,
  input  logic            JumpD,
  input  logic            BranchD,
  input  logic            ALUSrcD,
  input  logic [1:0]      ResultSrcD,
  input  logic [3:0]      ALUControlD,
  input  logic [2:0]      funct3D,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  input  logic [4:0]      RdD,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [4:0]      RdM,
  input  logic            RegWriteM,
  input  logic [XLEN-1:0] ResultW,
  input  logic [4:0]      RdW,
  input  logic            RegWriteW,
  output logic [XLEN-1:0] ALUResultE,
  output logic [XLEN-1:0] WriteDataE,
  output logic [XLEN-1:0] PCTargetE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic            PCSrcE,
  output logic            ValidE,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic [1:0]      ResultSrcE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE
);

  idex_t idex_d;
  idex_t idex_q;

  // ID/EX register: flush > stall > load (reset handled in the flop)
  always_comb begin
    idex_d = idex_q;
    if (FlushE) begin
      idex_d = '0;
    end else if (!StallE) begin
      idex_d.valid      = ValidD;
      idex_d.reg_write  = RegWriteD;
      idex_d.mem_write  = MemWriteD;
      idex_d.jump       = JumpD;
      idex_d.branch     = BranchD;
      idex_d.alu_src    = ALUSrcD;
      idex_d.result_src = ResultSrcD;
      idex_d.alu_ctrl   = ALUControlD;
      idex_d.funct3     = funct3D;
      idex_d.rd1        = RD1D;
      idex_d.rd2        = RD2D;
      idex_d.pc         = PCD;
      idex_d.imm        = ImmExtD;
      idex_d.pc_plus4   = PCPlus4D;
      idex_d.rs1        = Rs1D;
      idex_d.rs2        = Rs2D;
      idex_d.rd         = RdD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) idex_q <= '0;
    else       idex_q <= idex_d;
  end

  // EX: forwarding, MEM has priority over WB; x0 is never forwarded
  function automatic fwd_sel_t fwd_select(input logic [4:0] rs);
    if (RegWriteM && (RdM == rs) && (rs != 5'd0))      return FWD_MEM;
    else if (RegWriteW && (RdW == rs) && (rs != 5'd0)) return FWD_WB;
    else                                               return FWD_REG;
  endfunction

  fwd_sel_t        fwd_a_sel;
  fwd_sel_t        fwd_b_sel;
  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;
  logic            cond;
  logic            unused_funct3_bit1;

  always_comb begin
    fwd_a_sel = fwd_select(idex_q.rs1);
    fwd_b_sel = fwd_select(idex_q.rs2);
    case (fwd_a_sel)
      FWD_MEM: fwd_a = ALUResultM;
      FWD_WB:  fwd_a = ResultW;
      default: fwd_a = idex_q.rd1;
    endcase
    case (fwd_b_sel)
      FWD_MEM: fwd_b = ALUResultM;
      FWD_WB:  fwd_b = ResultW;
      default: fwd_b = idex_q.rd2;
    endcase
  end

  assign src_b = idex_q.alu_src ? idex_q.imm : fwd_b;

  alu u_alu (
    .src_a  (fwd_a),
    .src_b  (src_b),
    .op     (alu_op_t'(idex_q.alu_ctrl)),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // funct3[2] picks slt/sltu bit vs. zero flag; funct3[0] inverts the sense
  assign cond = (idex_q.funct3[2] ? alu_result[0] : alu_zero) ^ idex_q.funct3[0];
  assign unused_funct3_bit1 = idex_q.funct3[1];

  // A bubble (valid=0) never redirects, even with stale jump/branch bits
  assign PCSrcE     = idex_q.valid & (idex_q.jump | (idex_q.branch & cond));
  assign PCTargetE  = idex_q.pc + idex_q.imm;
  assign ALUResultE = alu_result;
  assign WriteDataE = fwd_b;
  assign PCPlus4E   = idex_q.pc_plus4;
  assign ValidE     = idex_q.valid;
  assign RegWriteE  = idex_q.reg_write;
  assign MemWriteE  = idex_q.mem_write;
  assign ResultSrcE = idex_q.result_src;
  assign Rs1E       = idex_q.rs1;
  assign Rs2E       = idex_q.rs2;
  assign RdE        = idex_q.rd;

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            StallE, FlushE;
  logic            ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0]      ResultSrcD;
  logic [3:0]      ALUControlD;
  logic [2:0]      funct3D;
  logic [XLEN-1:0] RD1D, RD2D, PCD, ImmExtD, PCPlus4D;
  logic [4:0]      Rs1D, Rs2D, RdD;
  logic [XLEN-1:0] ALUResultM, ResultW;
  logic [4:0]      RdM, RdW;
  logic            RegWriteM, RegWriteW;
  logic [XLEN-1:0] ALUResultE, WriteDataE, PCTargetE, PCPlus4E;
  logic            PCSrcE, ValidE, RegWriteE, MemWriteE;
  logic [1:0]      ResultSrcE;
  logic [4:0]      Rs1E, Rs2E, RdE;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
    .ValidD(ValidD), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD),
    .JumpD(JumpD), .BranchD(BranchD), .ALUSrcD(ALUSrcD),
    .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD), .funct3D(funct3D),
    .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .ImmExtD(ImmExtD), .PCPlus4D(PCPlus4D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ALUResultM(ALUResultM), .RdM(RdM), .RegWriteM(RegWriteM),
    .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .PCTargetE(PCTargetE),
    .PCPlus4E(PCPlus4E), .PCSrcE(PCSrcE), .ValidE(ValidE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, rw, mw, j, b, asrc,
                       input logic [3:0] op, input logic [2:0] f3,
                       input logic [31:0] a, bb, pc, imm,
                       input logic [4:0] rs1, rs2, rd);
    ValidD = v; RegWriteD = rw; MemWriteD = mw; JumpD = j; BranchD = b;
    ALUSrcD = asrc; ResultSrcD = 2'b01; ALUControlD = op; funct3D = f3;
    RD1D = a; RD2D = bb; PCD = pc; ImmExtD = imm; PCPlus4D = pc + 32'd4;
    Rs1D = rs1; Rs2D = rs2; RdD = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; StallE = 1'b0; FlushE = 1'b0;
    ALUResultM = '0; RdM = '0; RegWriteM = 1'b0;
    ResultW = '0; RdW = '0; RegWriteW = 1'b0;
    drive(1, 1, 1, 1, 1, 0, 4'b0000, 3'b000, 32'd11, 32'd22, 32'h40, 32'h8, 5'd3, 5'd4, 5'd9);
    tick(); tick();
    chk("rst_valid", {31'b0, ValidE}, 32'd0);
    chk("rst_pcsrc", {31'b0, PCSrcE}, 32'd0);
    chk("rst_rd", {27'b0, RdE}, 32'd0);
    chk("rst_alu", ALUResultE, 32'd0);
    reset = 1'b0;

    // jal loaded, then asynchronous reset between edges
    drive(1, 1, 0, 1, 0, 1, 4'b0000, 3'b000, 32'd0, 32'd0, 32'h200, 32'h80, 5'd0, 5'd0, 5'd1);
    tick();
    chk("jal_pcsrc", {31'b0, PCSrcE}, 32'd1);
    chk("jal_target", PCTargetE, 32'h280);
    chk("jal_pc4", PCPlus4E, 32'h204);
    chk("jal_rsrc", {30'b0, ResultSrcE}, 32'd1);
    drive(1, 1, 1, 1, 0, 0, 4'b0000, 3'b000, 32'd5, 32'd6, 32'h300, 32'h10, 5'd7, 5'd8, 5'd12);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", {31'b0, ValidE}, 32'd0);
    chk("arst_pcsrc", {31'b0, PCSrcE}, 32'd0);
    chk("arst_rd", {27'b0, RdE}, 32'd0);
    chk("arst_alu", ALUResultE, 32'd0);
    #1 reset = 1'b0;

    // forwarding
    drive(1, 1, 0, 0, 0, 0, 4'b0000, 3'b000, 32'd1, 32'd2, 32'h0, 32'h0, 5'd5, 5'd6, 5'd10);
    tick();
    chk("nofwd_add", ALUResultE, 32'd3);
    RdM = 5'd5; RegWriteM = 1'b1; ALUResultM = 32'd100;
    #1 chk("mem_fwd", ALUResultE, 32'd102);
    RdW = 5'd5; RegWriteW = 1'b1; ResultW = 32'd7;
    #1 chk("mem_over_wb", ALUResultE, 32'd102);
    RdM = 5'd9;
    #1 chk("wb_fwd", ALUResultE, 32'd9);
    RdM = 5'd6;
    #1 chk("mem_fwd_b_wd", WriteDataE, 32'd100);
    chk("mem_fwd_b_alu", ALUResultE, 32'd107);
    RdM = 5'd0; RdW = 5'd0;
    drive(1, 1, 0, 0, 0, 0, 4'b0000, 3'b000, 32'd1, 32'd2, 32'h0, 32'h0, 5'd0, 5'd6, 5'd10);
    tick();
    chk("x0_nofwd", ALUResultE, 32'd3);
    RegWriteM = 1'b0; RegWriteW = 1'b0;

    // branches
    drive(1, 0, 0, 0, 1, 0, 4'b0001, 3'b000, 32'd9, 32'd9, 32'h100, 32'h40, 5'd1, 5'd2, 5'd0);
    tick();
    chk("beq_taken", {31'b0, PCSrcE}, 32'd1);
    chk("beq_target", PCTargetE, 32'h140);
    drive(1, 0, 0, 0, 1, 0, 4'b0001, 3'b001, 32'd9, 32'd9, 32'h100, 32'h40, 5'd1, 5'd2, 5'd0);
    tick();
    chk("bne_not", {31'b0, PCSrcE}, 32'd0);
    drive(1, 0, 0, 0, 1, 0, 4'b0101, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h40, 5'd1, 5'd2, 5'd0);
    tick();
    chk("blt_taken", {31'b0, PCSrcE}, 32'd1);
    chk("slt_res", ALUResultE, 32'd1);
    drive(1, 0, 0, 0, 1, 0, 4'b1001, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h40, 5'd1, 5'd2, 5'd0);
    tick();
    chk("bltu_not", {31'b0, PCSrcE}, 32'd0);
    chk("sltu_res", ALUResultE, 32'd0);

    // shifts and unused code
    drive(1, 1, 0, 0, 0, 1, 4'b0111, 3'b000, 32'h8000_0000, 32'd0, 32'h0, 32'h24, 5'd1, 5'd2, 5'd3);
    tick();
    chk("sra", ALUResultE, 32'hF800_0000);
    drive(1, 1, 0, 0, 0, 1, 4'b0110, 3'b000, 32'h8000_0000, 32'd0, 32'h0, 32'h24, 5'd1, 5'd2, 5'd3);
    tick();
    chk("srl", ALUResultE, 32'h0800_0000);
    drive(1, 1, 0, 0, 0, 1, 4'b1000, 3'b000, 32'h0000_0003, 32'd0, 32'h0, 32'h24, 5'd1, 5'd2, 5'd3);
    tick();
    chk("sll", ALUResultE, 32'h0000_0030);
    drive(1, 1, 0, 0, 0, 1, 4'b1100, 3'b000, 32'h8000_0000, 32'd0, 32'h0, 32'h24, 5'd1, 5'd2, 5'd3);
    tick();
    chk("code1100", ALUResultE, 32'd0);

    // bubble with stale jump never redirects
    drive(0, 1, 0, 1, 0, 0, 4'b0000, 3'b000, 32'd1, 32'd1, 32'h0, 32'h4, 5'd1, 5'd2, 5'd3);
    tick();
    chk("bubble_pcsrc", {31'b0, PCSrcE}, 32'd0);

    // flush beats stall
    drive(1, 1, 0, 1, 0, 0, 4'b0000, 3'b000, 32'd0, 32'd0, 32'h400, 32'h20, 5'd0, 5'd0, 5'd1);
    tick();
    chk("jal2_pcsrc", {31'b0, PCSrcE}, 32'd1);
    FlushE = 1'b1; StallE = 1'b1;
    tick();
    chk("flush_valid", {31'b0, ValidE}, 32'd0);
    chk("flush_pcsrc", {31'b0, PCSrcE}, 32'd0);
    chk("flush_rd", {27'b0, RdE}, 32'd0);
    FlushE = 1'b0; StallE = 1'b0;

    // stall holds for 3 cycles while D changes
    drive(1, 1, 1, 0, 0, 0, 4'b0000, 3'b000, 32'd3, 32'd4, 32'h500, 32'h0, 5'd1, 5'd2, 5'd7);
    tick();
    chk("pre_stall_alu", ALUResultE, 32'd7);
    StallE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 1, 0, 1, 4'b0001, 3'b000, 32'd50 + i, 32'd1, 32'h600, 32'h8, 5'd11, 5'd12, 5'd13 + i[4:0]);
      tick();
      chk("stall_alu", ALUResultE, 32'd7);
      chk("stall_rd", {27'b0, RdE}, 32'd7);
      chk("stall_pcsrc", {31'b0, PCSrcE}, 32'd0);
      chk("stall_mw", {31'b0, MemWriteE}, 32'd1);
    end
    StallE = 1'b0;
    tick();
    chk("post_stall_rd", {27'b0, RdE}, 32'd15);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
